// File: rtl/frecv_pkg.sv
// Shared types and default sizes for the frequency-profile scheduler.
package frecv_pkg;

  localparam int FRECV_WIDTH   = 6;
  localparam int FRECV_DEPTH   = 4;
  localparam int FRECV_PRESC_W = 8;
  localparam int FRECV_REPS_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_NEXT = 2'd3
  } state_e;

  // Layout of one profile entry at the default width.
  typedef struct packed {
    logic [FRECV_WIDTH-1:0]  high;
    logic [FRECV_WIDTH-1:0]  low;
    logic [FRECV_REPS_W-1:0] reps;
  } entry_t;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/frecv_presc.sv
// Tick divider: one-cycle tick every presc+1 enabled cycles, counted from the first enabled cycle.
module frecv_presc
  import frecv_pkg::*;
#(
  parameter int PRESC_W = FRECV_PRESC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               en_q;
  logic               tick_d;

  // Divider next state; the first enabled edge only arms the counter.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!en || !en_q) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else if (cnt_q >= presc) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + PRESC_W'(1);
      tick_d = 1'b0;
    end
  end

  // Divider registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en;
      tick  <= tick_d;
    end
  end

endmodule

// File: rtl/frecv_sched.sv
// Frequency-profile scheduler: walks a table of {high, low, reps} entries feeding a period generator.
// Build option: FRECV_SCHED_LOOP_EN wraps each pass back to entry 0 instead of ending the sequence.
module frecv_sched
  import frecv_pkg::*;
#(
  parameter  int WIDTH   = FRECV_WIDTH,
  parameter  int DEPTH   = FRECV_DEPTH,
  parameter  int PRESC_W = FRECV_PRESC_W,
  localparam int IW      = idx_w(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_high,
  input  logic [WIDTH-1:0]   wr_low,
  input  logic [7:0]         wr_reps,
  input  logic [IW-1:0]      last_idx,
  input  logic [PRESC_W-1:0] presc,
  input  logic               start,
  input  logic               stop,
  input  logic               gen_done,
  output logic [WIDTH-1:0]   t_high_o,
  output logic [WIDTH-1:0]   t_low_o,
  output logic               gen_load,
  output logic               tick_o,
  output logic               busy,
  output logic [IW-1:0]      idx_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int RW = FRECV_REPS_W;

  typedef struct packed {
    logic [WIDTH-1:0] high;
    logic [WIDTH-1:0] low;
    logic [RW-1:0]    reps;
  } tbl_entry_t;

  tbl_entry_t       table_q [DEPTH];
  tbl_entry_t       entry_s;
  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d, last_eff_s;
  logic [RW-1:0]    rep_q, rep_d, reps_q, reps_d;
  logic [WIDTH-1:0] t_high_q, t_high_d, t_low_q, t_low_d;
  logic             gen_load_q, gen_load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             played_q, played_d;
  logic             accept_start_s, pass_end_s;
  logic             tick_s;

  assign last_eff_s = (32'(last_idx) >= DEPTH) ? IW'(DEPTH - 1) : last_idx;

  // Profile table; writes are accepted in every state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
      table_q[wr_addr] <= {wr_high, wr_low, wr_reps};
    end else begin
      table_q <= table_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop overrides everything outside IDLE
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    rep_d          = rep_q;
    accept_start_s = 1'b0;
    pass_end_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d        = ST_LOAD;
          idx_d          = '0;
          accept_start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        rep_d = '0;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (gen_load_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (gen_done) begin
          rep_d = rep_q + RW'(1);
          if ((rep_q + RW'(1)) == reps_q) begin
            state_d = ST_NEXT;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_NEXT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (idx_q < last_eff_s) begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_LOAD;
        end else begin
          pass_end_s = 1'b1;
`ifdef FRECV_SCHED_LOOP_EN
          idx_d   = '0;
          state_d = ST_LOAD;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the LOAD cycle itself carries gen_load
  always_comb begin
    entry_s    = table_q[idx_d];
    t_high_d   = t_high_q;
    t_low_d    = t_low_q;
    reps_d     = reps_q;
    gen_load_d = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    err_d      = accept_start_s ? 1'b0 : err_q;
    played_d   = accept_start_s ? 1'b0 : played_q;
    done_d     = pass_end_s && played_q && (state_d == ST_IDLE);
    if (state_d == ST_LOAD) begin
      if ((entry_s.high == '0) || (entry_s.low == '0)) begin
        err_d = 1'b1;
      end else if (entry_s.reps != '0) begin
        gen_load_d = 1'b1;
        t_high_d   = entry_s.high;
        t_low_d    = entry_s.low;
        reps_d     = entry_s.reps;
        played_d   = 1'b1;
      end else begin
        gen_load_d = 1'b0;
      end
    end else begin
      gen_load_d = 1'b0;
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      rep_q      <= '0;
      reps_q     <= '0;
      t_high_q   <= '0;
      t_low_q    <= '0;
      gen_load_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      played_q   <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      rep_q      <= rep_d;
      reps_q     <= reps_d;
      t_high_q   <= t_high_d;
      t_low_q    <= t_low_d;
      gen_load_q <= gen_load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      played_q   <= played_d;
    end
  end

  frecv_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (busy_d),
    .presc (presc),
    .tick  (tick_s)
  );

  assign t_high_o = t_high_q;
  assign t_low_o  = t_low_q;
  assign gen_load = gen_load_q;
  assign tick_o   = tick_s;
  assign busy     = busy_q;
  assign idx_o    = idx_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_frecv_sched.sv
// Scoreboard bench for frecv_sched: directed sequences push expected gen_load/done_o events, a monitor checks them.
module tb_frecv_sched;
  import frecv_pkg::*;

  localparam int W  = FRECV_WIDTH;
  localparam int IW = 2;
  localparam int PW = FRECV_PRESC_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_high = '0;
  logic [W-1:0]  wr_low = '0;
  logic [7:0]    wr_reps = '0;
  logic [IW-1:0] last_idx = '0;
  logic [PW-1:0] presc = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          gen_done = 1'b0;
  logic [W-1:0]  t_high_o, t_low_o;
  logic          gen_load, tick_o, busy, done_o, err_o;
  logic [IW-1:0] idx_o;

  frecv_sched dut (
    .clk(clk), .reset(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_high(wr_high),
    .wr_low(wr_low), .wr_reps(wr_reps), .last_idx(last_idx), .presc(presc),
    .start(start), .stop(stop), .gen_done(gen_done), .t_high_o(t_high_o),
    .t_low_o(t_low_o), .gen_load(gen_load), .tick_o(tick_o), .busy(busy),
    .idx_o(idx_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          load;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [IW-1:0] idx;
    logic          err;
    logic          busy;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic ev_t ev(input logic ld, input logic dn, input logic [W-1:0] hi,
                             input logic [W-1:0] lo, input logic [IW-1:0] idx,
                             input logic err, input logic bz);
    ev_t e;
    e = {ld, dn, hi, lo, idx, err, bz};
    return e;
  endfunction

  // Monitor: every gen_load or done_o pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst_n && (gen_load || done_o)) begin
      ev_t act;
      ev_t req;
      act = {gen_load, done_o, t_high_o, t_low_o, idx_o, err_o, busy};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got 0x%0h required none", act);
      end else begin
        req = exp_q.pop_front();
        check("event", 32'(act), 32'(req));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [IW-1:0] a, input logic [W-1:0] h, input logic [W-1:0] l,
                    input logic [7:0] r);
    wr_en = 1'b1; wr_addr = a; wr_high = h; wr_low = l; wr_reps = r;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic done_pulse();
    gen_done = 1'b1;
    step(1);
    gen_done = 1'b0;
  endtask

  task automatic count_ticks(input int n, output int cnt, output int first);
    cnt = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tick_o) begin
        cnt++;
        if (first < 0) first = i;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cnt;
    int first;

    #12;
    check("reset_outputs", 32'({t_high_o, t_low_o, gen_load, tick_o, busy, idx_o, done_o, err_o}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);

`ifndef FRECV_SCHED_LOOP_EN
    // Two-entry pass; entry1 rewritten and entry0 overwritten while entry0 runs.
    presc = '0; last_idx = 2'd1;
    wr(2'd0, 6'd3, 6'd2, 8'd2);
    wr(2'd1, 6'd6, 6'd6, 8'd1);
    exp_q.push_back(ev(1'b1, 1'b0, 6'd3, 6'd2, 2'd0, 1'b0, 1'b1));
    exp_q.push_back(ev(1'b1, 1'b0, 6'd1, 6'd4, 2'd1, 1'b0, 1'b1));
    exp_q.push_back(ev(1'b0, 1'b1, 6'd1, 6'd4, 2'd1, 1'b0, 1'b0));
    start_pulse();
    step(1);
    wr(2'd1, 6'd1, 6'd4, 8'd1);
    wr(2'd0, 6'd7, 6'd7, 8'd1);
    check("latched_high_kept", 32'(t_high_o), 32'd3);
    done_pulse();
    done_pulse();
    step(1);
    step(1);
    done_pulse();
    step(1);
    step(1);
    check("done_single_cycle", 32'({done_o, busy}), 32'd0);

    // Invalid entry0 is skipped with err_o set.
    wr(2'd0, 6'd0, 6'd5, 8'd1);
    wr(2'd1, 6'd2, 6'd2, 8'd1);
    exp_q.push_back(ev(1'b1, 1'b0, 6'd2, 6'd2, 2'd1, 1'b1, 1'b1));
    exp_q.push_back(ev(1'b0, 1'b1, 6'd2, 6'd2, 2'd1, 1'b1, 1'b0));
    start_pulse();
    step(2);
    step(1);
    done_pulse();
    step(2);
    check("err_sticky_idle", 32'(err_o), 32'd1);
`endif

    // Prescaler at 3 then 0; a start while busy must not reload.
    presc = 8'd3; last_idx = 2'd0;
    wr(2'd0, 6'd5, 6'd5, 8'd20);
    exp_q.push_back(ev(1'b1, 1'b0, 6'd5, 6'd5, 2'd0, 1'b0, 1'b1));
    start_pulse();
    count_ticks(16, cnt, first);
    check("tick_first_p3", 32'(first), 32'd4);
    check("tick_count_p3", 32'(cnt), 32'd3);
    presc = 8'd0;
    start_pulse();
    count_ticks(8, cnt, first);
    check("tick_count_p0", 32'(cnt), 32'd8);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_idle", 32'({busy, tick_o}), 32'd0);

    // Stop and gen_done together on the final repetition.
    wr(2'd0, 6'd1, 6'd1, 8'd1);
    exp_q.push_back(ev(1'b1, 1'b0, 6'd1, 6'd1, 2'd0, 1'b0, 1'b1));
    start_pulse();
    step(1);
    gen_done = 1'b1; stop = 1'b1;
    step(1);
    gen_done = 1'b0; stop = 1'b0;
    check("stop_beats_done", 32'(busy), 32'd0);
    step(3);

`ifndef FRECV_SCHED_LOOP_EN
    // reps==0 skip leaves err_o clear; gen_done in the load cycle is ignored.
    last_idx = 2'd1;
    wr(2'd0, 6'd2, 6'd3, 8'd0);
    wr(2'd1, 6'd4, 6'd1, 8'd1);
    exp_q.push_back(ev(1'b1, 1'b0, 6'd4, 6'd1, 2'd1, 1'b0, 1'b1));
    exp_q.push_back(ev(1'b0, 1'b1, 6'd4, 6'd1, 2'd1, 1'b0, 1'b0));
    start_pulse();
    step(2);
    gen_done = 1'b1;
    step(1);
    gen_done = 1'b0;
    step(1);
    check("load_done_ignored", 32'(busy), 32'd1);
    done_pulse();
    step(2);
`endif

    // Asynchronous reset in the middle of a run.
    last_idx = 2'd1;
    wr(2'd0, 6'd0, 6'd1, 8'd1);
    wr(2'd1, 6'd2, 6'd2, 8'd3);
    exp_q.push_back(ev(1'b1, 1'b0, 6'd2, 6'd2, 2'd1, 1'b1, 1'b1));
    start_pulse();
    step(3);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({t_high_o, t_low_o, gen_load, tick_o, busy, idx_o, done_o, err_o}), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

`ifndef FRECV_SCHED_LOOP_EN
    // Cleared table: every entry is skipped, pass ends with err_o and no done_o.
    last_idx = 2'd3;
    start_pulse();
    step(10);
    check("all_skipped", 32'({busy, err_o}), 32'd1);
`else
    last_idx = 2'd1;
    wr(2'd0, 6'd1, 6'd1, 8'd1);
    wr(2'd1, 6'd2, 6'd2, 8'd1);
    exp_q.push_back(ev(1'b1, 1'b0, 6'd1, 6'd1, 2'd0, 1'b0, 1'b1));
    exp_q.push_back(ev(1'b1, 1'b0, 6'd2, 6'd2, 2'd1, 1'b0, 1'b1));
    exp_q.push_back(ev(1'b1, 1'b0, 6'd1, 6'd1, 2'd0, 1'b0, 1'b1));
    exp_q.push_back(ev(1'b1, 1'b0, 6'd2, 6'd2, 2'd1, 1'b0, 1'b1));
    start_pulse();
    for (int k = 0; k < 3; k++) begin
      step(1);
      done_pulse();
      step(1);
    end
    step(1);
    check("loop_still_busy", 32'({busy, done_o}), 32'd2);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("loop_stopped", 32'(busy), 32'd0);
`endif

    step(2);
    check("events_left", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
